wb_ibus_dbus_arbiter: RTL

WB_IBUS_DBUS_ARBITER -- requirements
Module: wb_ibus_dbus_arbiter

---
 rtl/wb_ibus_dbus_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wb_ibus_dbus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone arbiter.
// Optional slave-stall timeout enabled by `define WB_ARBITER_TIMEOUT_EN.
module wb_ibus_dbus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit FIRST_GRANT_D  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction master
  input  logic [31:0] iwb_adr_i,
  input  logic [31:0] iwb_dat_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  input  logic        iwb_we_i,
  input  logic [3:0]  iwb_sel_i,
  input  logic [2:0]  iwb_cti_i,
  input  logic [1:0]  iwb_bte_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  output logic        iwb_rty_o,
  // data master
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  input  logic        dwb_we_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic [2:0]  dwb_cti_i,
  input  logic [1:0]  dwb_bte_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic        dwb_rty_o,
  // shared slave
  output logic [31:0] swb_adr_o,
  output logic [31:0] swb_dat_o,
  output logic        swb_cyc_o,
  output logic        swb_stb_o,
  output logic        swb_we_o,
  output logic [3:0]  swb_sel_o,
  output logic [2:0]  swb_cti_o,
  output logic [1:0]  swb_bte_o,
  input  logic [31:0] swb_dat_i,
  input  logic        swb_ack_i,
  input  logic        swb_err_i,
  input  logic        swb_rty_i,
  // grant
  output logic [1:0]  arb_gnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_d;
  logic   w_last_d;
  logic   w_gnt_i;
  logic   w_gnt_d;
  logic   w_tmo;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_tmo_range
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  assign w_gnt_i   = (r_state == GNT_I);
  assign w_gnt_d   = (r_state == GNT_D);
  assign arb_gnt_o = r_state;

`ifdef WB_ARBITER_TIMEOUT_EN
  localparam logic [7:0] LP_TMO = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_tmo;
  logic       w_resp;

  assign w_resp = swb_ack_i | swb_err_i | swb_rty_i;
  assign w_tmo  = (r_state != IDLE) && (r_tmo == LP_TMO);

  // stall counter: held at 0 in idle so each grant starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (r_state == IDLE || w_resp || w_tmo) begin
      r_tmo <= '0;
    end else if (swb_stb_o) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // state and last-served registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= ~FIRST_GRANT_D;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_last_d;
    end
  end

  // next state: arbitrate from idle, hold grant while owner keeps cyc
  always_comb begin
    w_next   = r_state;
    w_last_d = r_last_d;
    unique case (r_state)
      IDLE: begin
        if (iwb_cyc_i && dwb_cyc_i) begin
          w_next = r_last_d ? GNT_I : GNT_D;
        end else if (iwb_cyc_i) begin
          w_next = GNT_I;
        end else if (dwb_cyc_i) begin
          w_next = GNT_D;
        end
      end
      GNT_I: begin
        if (!iwb_cyc_i || w_tmo) begin
          w_next   = IDLE;
          w_last_d = 1'b0;
        end
      end
      GNT_D: begin
        if (!dwb_cyc_i || w_tmo) begin
          w_next   = IDLE;
          w_last_d = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // slave-side mux of the granted master
  always_comb begin
    swb_adr_o = '0;
    swb_dat_o = '0;
    swb_cyc_o = 1'b0;
    swb_stb_o = 1'b0;
    swb_we_o  = 1'b0;
    swb_sel_o = '0;
    swb_cti_o = '0;
    swb_bte_o = '0;
    if (w_gnt_i) begin
      swb_adr_o = iwb_adr_i;
      swb_dat_o = iwb_dat_i;
      swb_cyc_o = iwb_cyc_i & ~w_tmo;
      swb_stb_o = iwb_stb_i & ~w_tmo;
      swb_we_o  = iwb_we_i;
      swb_sel_o = iwb_sel_i;
      swb_cti_o = iwb_cti_i;
      swb_bte_o = iwb_bte_i;
    end else if (w_gnt_d) begin
      swb_adr_o = dwb_adr_i;
      swb_dat_o = dwb_dat_i;
      swb_cyc_o = dwb_cyc_i & ~w_tmo;
      swb_stb_o = dwb_stb_i & ~w_tmo;
      swb_we_o  = dwb_we_i;
      swb_sel_o = dwb_sel_i;
      swb_cti_o = dwb_cti_i;
      swb_bte_o = dwb_bte_i;
    end
  end

  // responses go to the owner only; a timeout replaces them with err
  always_comb begin
    iwb_dat_o = swb_dat_i;
    dwb_dat_o = swb_dat_i;
    iwb_ack_o = w_gnt_i & swb_ack_i & ~w_tmo;
    iwb_rty_o = w_gnt_i & swb_rty_i & ~w_tmo;
    iwb_err_o = w_gnt_i & ((swb_err_i & ~w_tmo) | w_tmo);
    dwb_ack_o = w_gnt_d & swb_ack_i & ~w_tmo;
    dwb_rty_o = w_gnt_d & swb_rty_i & ~w_tmo;
    dwb_err_o = w_gnt_d & ((swb_err_i & ~w_tmo) | w_tmo);
  end

endmodule
